// File: rtl/id_ex_pipe_reg_if.sv
// Decode->execute pipeline register bus: D-side inputs, hazard controls and E-side outputs.
interface id_ex_pipe_reg_if #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ALUSEL_W = 3
);
  logic                stallE;
  logic                flushE;

  logic                validD;
  logic                rfweD;
  logic                mtorfselD;
  logic                dmweD;
  logic                branchD;
  logic                aluinselD;
  logic                rfdselD;
  logic [ALUSEL_W-1:0] aluselD;
  logic [DW-1:0]       RFRD1D;
  logic [DW-1:0]       RFRD2D;
  logic [AW-1:0]       rtD;
  logic [AW-1:0]       rdD;
  logic [DW-1:0]       simmD;
  logic [DW-1:0]       pcoutD;

  logic                validE;
  logic                rfweE;
  logic                mtorfselE;
  logic                dmweE;
  logic                branchE;
  logic                aluinselE;
  logic                rfdselE;
  logic [ALUSEL_W-1:0] aluselE;
  logic [DW-1:0]       RFRD1E;
  logic [DW-1:0]       RFRD2E;
  logic [AW-1:0]       rtE;
  logic [AW-1:0]       rdE;
  logic [DW-1:0]       simmE;
  logic [DW-1:0]       pcoutE;

  modport master (
    output stallE, flushE,
    output validD, rfweD, mtorfselD, dmweD, branchD, aluinselD, rfdselD,
    output aluselD, RFRD1D, RFRD2D, rtD, rdD, simmD, pcoutD,
    input  validE, rfweE, mtorfselE, dmweE, branchE, aluinselE, rfdselE,
    input  aluselE, RFRD1E, RFRD2E, rtE, rdE, simmE, pcoutE
  );

  modport slave (
    input  stallE, flushE,
    input  validD, rfweD, mtorfselD, dmweD, branchD, aluinselD, rfdselD,
    input  aluselD, RFRD1D, RFRD2D, rtD, rdD, simmD, pcoutD,
    output validE, rfweE, mtorfselE, dmweE, branchE, aluinselE, rfdselE,
    output aluselE, RFRD1E, RFRD2E, rtE, rdE, simmE, pcoutE
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with valid bit, stall (hold) and flush (bubble).
// Optional stall/flush performance counters enabled by macro DTOE_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_pipe_reg_if.slave  bus
`ifdef DTOE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int W = 7 + ALUSEL_W + 4 * DW + 2 * AW;

  if (CNT_W < 1 || DW < 1 || AW < 1 || ALUSEL_W < 1) begin : g_param_check
    $error("id_ex_pipe_reg: all width parameters must be >= 1");
  end

  logic [W-1:0] d_vec;
  logic [W-1:0] e_reg;

  // All fields travel as one flat word so load/hold/bubble apply uniformly.
  assign d_vec = {bus.validD, bus.rfweD, bus.mtorfselD, bus.dmweD, bus.branchD,
                  bus.aluinselD, bus.rfdselD, bus.aluselD, bus.RFRD1D, bus.RFRD2D,
                  bus.rtD, bus.rdD, bus.simmD, bus.pcoutD};

  assign {bus.validE, bus.rfweE, bus.mtorfselE, bus.dmweE, bus.branchE,
          bus.aluinselE, bus.rfdselE, bus.aluselE, bus.RFRD1E, bus.RFRD2E,
          bus.rtE, bus.rdE, bus.simmE, bus.pcoutE} = e_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_reg <= '0;
    end else if (bus.flushE) begin
      e_reg <= '0;
    end else if (!bus.stallE) begin
      e_reg <= d_vec;
    end
  end

`ifdef DTOE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Counters saturate at all-ones and clear only on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (bus.flushE) begin
      if (flush_cnt_reg != '1) flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end else if (bus.stallE) begin
      if (stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: stimulus queues expected E state, a negedge monitor checks it.
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int AS = 3;
`ifdef DTOE_PERF_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  typedef struct packed {
    logic          valid;
    logic          rfwe;
    logic          mtorfsel;
    logic          dmwe;
    logic          branch;
    logic          aluinsel;
    logic          rfdsel;
    logic [AS-1:0] alusel;
    logic [DW-1:0] rfrd1;
    logic [DW-1:0] rfrd2;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] simm;
    logic [DW-1:0] pcout;
  } stage_t;

  typedef struct packed {
    stage_t        st;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] stall_cnt_w;
  logic [CW-1:0] flush_cnt_w;

  id_ex_pipe_reg_if #(.DW(DW), .AW(AW), .ALUSEL_W(AS)) bus ();

  id_ex_pipe_reg #(.DW(DW), .AW(AW), .ALUSEL_W(AS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DTOE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt_w),
    .flush_cnt (flush_cnt_w)
`endif
  );

`ifndef DTOE_PERF_CNT_EN
  assign stall_cnt_w = '0;
  assign flush_cnt_w = '0;
`endif

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  exp_t  model = '0;

  function automatic stage_t get_e();
    stage_t s;
    s = {bus.validE, bus.rfweE, bus.mtorfselE, bus.dmweE, bus.branchE, bus.aluinselE,
         bus.rfdselE, bus.aluselE, bus.RFRD1E, bus.RFRD2E, bus.rtE, bus.rdE,
         bus.simmE, bus.pcoutE};
    return s;
  endfunction

  task automatic drive_d(input stage_t s);
    bus.validD = s.valid;     bus.rfweD = s.rfwe;         bus.mtorfselD = s.mtorfsel;
    bus.dmweD = s.dmwe;       bus.branchD = s.branch;     bus.aluinselD = s.aluinsel;
    bus.rfdselD = s.rfdsel;   bus.aluselD = s.alusel;     bus.RFRD1D = s.rfrd1;
    bus.RFRD2D = s.rfrd2;     bus.rtD = s.rt;             bus.rdD = s.rd;
    bus.simmD = s.simm;       bus.pcoutD = s.pcout;
  endtask

  // One clock cycle: apply inputs, queue the state expected after the edge.
  task automatic step(input string nm, input logic r, input logic fl, input logic st,
                      input stage_t d);
    rst = r;
    bus.flushE = fl;
    bus.stallE = st;
    drive_d(d);
    if (r) begin
      model = '0;
    end else if (fl) begin
      model.st = '0;
      if (model.fcnt != {CW{1'b1}}) model.fcnt = model.fcnt + 1'b1;
    end else if (st) begin
      if (model.scnt != {CW{1'b1}}) model.scnt = model.scnt + 1'b1;
    end else begin
      model.st = d;
    end
`ifndef DTOE_PERF_CNT_EN
    model.scnt = '0;
    model.fcnt = '0;
`endif
    exp_q.push_back(model);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic stage_t mk(input logic v, input logic [AS-1:0] op, input logic [DW-1:0] a,
                                input logic [AW-1:0] rd, input logic we, input logic dw);
    stage_t s;
    s = '0;
    s.valid = v; s.alusel = op; s.rfrd1 = a; s.rd = rd; s.rfwe = we; s.dmwe = dw;
    s.rfrd2 = ~a; s.rt = rd ^ 5'h15; s.simm = a + 32'h10; s.pcout = a ^ 32'hA5A5_0000;
    s.mtorfsel = a[0]; s.branch = a[1]; s.aluinsel = a[2]; s.rfdsel = a[3];
    return s;
  endfunction

  // Monitor: the DUT presents a new E state every cycle; check it mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    exp_t  act;
    string nm;
    cycle++;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act.st = get_e();
      act.scnt = stall_cnt_w;
      act.fcnt = flush_cnt_w;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got E=%h cnt=%0d/%0d, expected E=%h cnt=%0d/%0d", nm,
                 act.st, act.scnt, act.fcnt, e.st, e.scnt, e.fcnt);
      end else begin
        $display("chk %0d %s ok E=%h cnt=%0d/%0d", checks, nm, act.st, act.scnt, act.fcnt);
      end
    end
  end

  initial begin
    stage_t ones;
    stage_t t2;
    stage_t bub;
    ones = '1;
    bub = '0;
    bus.stallE = 1'b0;
    bus.flushE = 1'b0;
    drive_d(ones);
    #1;

    step("reset0", 1'b1, 1'b0, 1'b0, ones);
    step("reset1", 1'b1, 1'b0, 1'b0, ones);

    t2 = '0;
    t2.valid = 1'b1; t2.rfrd1 = 32'h1234_5678; t2.rd = 5'd9; t2.alusel = 3'b010; t2.rfwe = 1'b1;
    step("load_basic", 1'b0, 1'b0, 1'b0, t2);

    step("load_pre_stall", 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd5, 32'hDEAD_BEEF, 5'd17, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      step("stall_hold", 1'b0, 1'b0, 1'b1, mk(1'b1, AS'(i), 32'h0000_1000 * (i + 1), AW'(i + 3), 1'b0, 1'b1));
    step("stall_release", 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd7, 32'hCAFE_F00D, 5'd31, 1'b0, 1'b1));

    step("flush_over_stall", 1'b0, 1'b1, 1'b1, mk(1'b1, 3'd3, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b1));
    step("stall_bubble", 1'b0, 1'b0, 1'b1, mk(1'b1, 3'd1, 32'h5555_AAAA, 5'd2, 1'b1, 1'b1));
    step("load_invalid", 1'b0, 1'b0, 1'b0, mk(1'b0, 3'd6, 32'h0BAD_0001, 5'd8, 1'b1, 1'b0));

    step("load_pre_rst", 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd4, 32'h8000_0000, 5'd12, 1'b1, 1'b0));
    step("stall_pre_rst", 1'b0, 1'b0, 1'b1, mk(1'b1, 3'd2, 32'h7777_7777, 5'd13, 1'b1, 1'b1));
    step("rst_mid_stall", 1'b1, 1'b0, 1'b1, mk(1'b1, 3'd2, 32'h7777_7777, 5'd13, 1'b1, 1'b1));
    step("stall_after_rst", 1'b0, 1'b0, 1'b1, mk(1'b1, 3'd1, 32'h3333_3333, 5'd14, 1'b1, 1'b1));
    step("load_after_rst", 1'b0, 1'b0, 1'b0, mk(1'b1, 3'd1, 32'h3333_3333, 5'd14, 1'b1, 1'b1));
    step("rst_mid_flush", 1'b1, 1'b1, 1'b0, ones);
    step("load_after_rst2", 1'b0, 1'b0, 1'b0, ones);

`ifdef DTOE_PERF_CNT_EN
    step("cnt_clear", 1'b1, 1'b0, 1'b0, bub);
    for (int i = 0; i < 20; i++)
      step("stall_cnt_sat", 1'b0, 1'b0, 1'b1, mk(1'b1, 3'd0, 32'(i), 5'd1, 1'b0, 1'b0));
    step("flush_cnt_1", 1'b0, 1'b1, 1'b0, ones);
    step("flush_cnt_2", 1'b0, 1'b1, 1'b1, ones);
    step("cnt_rst", 1'b1, 1'b0, 1'b0, ones);
`endif

    step("idle", 1'b0, 1'b0, 1'b0, bub);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected states never checked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
